alu_operand_loader: RTL and testbench
=====================================

Name: alu_operand_loader

Overview:
- Upstream entry stage for the 4-bit ALU/seven-segment datapath. Operands and the opcode are all entered on one 4-bit switch bank.
- The operator presses NEXT to capture, in order: X, then Y, then the opcode.
- Debounced button edges drive a 4-state FSM. The FSM fills staging registers, then commits x/y/select to the ALU atomically, so the ALU never sees a partially entered operation.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed before a synchronised button level is accepted. Minimum 2; use 4 in simulation.
- CNT_W, 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset: asserts immediately, released synchronously to clk.
- sw  in  4  raw data switches; sampled only when a NEXT press is accepted.
- btn_next_raw  in  1  raw NEXT button, active high, asynchronous to clk.
- btn_clr_raw  in  1  raw CLEAR button, active high, asynchronous to clk.
- x  out  4  committed operand X, to the ALU.
- y  out  4  committed operand Y, to the ALU.
- select  out  3  committed opcode, to the ALU.
- op_valid  out  1  high while x/y/select hold a complete committed operation.
- commit_pulse  out  1  one-cycle strobe, high in the cycle after a commit.
- stage  out  2  current FSM state, driven to LEDs.

Behaviour:
- Reset (rst=0): x, y, select, staging registers, debounce counters and stable levels all go to 0. op_valid=0, commit_pulse=0, stage=LOAD_X.
- Synchronisation: each raw button passes through a 2-flop synchroniser into a debouncer.
- Debounce counter rules:
  - Counter increments on every edge where the synchronised level differs from the stable level.
  - Counter resets to 0 on any edge where the two levels match.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the stable level takes the synchronised value and the counter goes to 0.
- Press event: the stable level rose on the previous edge. Only rising edges count; releases are ignored.
- Latency: raw level held from just before edge 1 -> stable level changes at edge 2+DEBOUNCE_CYCLES -> FSM acts at edge 3+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES after synchronisation produce no event.
- FSM state encodings: LOAD_X=0, LOAD_Y=1, LOAD_OP=2, READY=3.
- FSM transitions on a NEXT event:
  - LOAD_X: stg_x <= sw; go to LOAD_Y.
  - LOAD_Y: stg_y <= sw; go to LOAD_OP.
  - LOAD_OP: stg_op <= sw[2:0] (sw[3] ignored). On the same edge: x<=stg_x, y<=stg_y, select<=sw[2:0], op_valid<=1, commit_pulse<=1. Go to READY.
  - READY: go to LOAD_X. x/y/select/op_valid are held, so the previous result stays displayed while a new entry is made.
- op_valid drops only on CLEAR or reset.
- A new commit overwrites x/y/select in a single edge.
- CLEAR event, in any state: go to LOAD_X; clear staging registers, x, y and select to 0; op_valid<=0; commit_pulse<=0.
- Simultaneous NEXT and CLEAR events on the same edge: CLEAR wins, and NEXT is discarded.
- NEXT held down: produces exactly one event. Another event needs release, then a debounced press.
- sw changes between presses: no effect; only the value present on the event edge is captured.
- Reset during debounce or mid-entry: everything returns to reset values. No event fires after release until a fresh, fully debounced press.
- commit_pulse is high for exactly one cycle per commit.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared include file alu_loader_defs.vh holds:
  - state encodings LOAD_X/LOAD_Y/LOAD_OP/READY;
  - opcode constants OP_ADD=0, OP_SUB=1, OP_NOT=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_LT=6, OP_EQ=7, shared with the ALU.
- Sub-module btn_debounce (parameters DEBOUNCE_CYCLES and CNT_W):
  - contains the synchroniser, counter and stable register, and outputs a one-cycle rise_pulse;
  - instantiated twice, for NEXT and CLEAR.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold rst=0, then release -> x=0, y=0, select=0, op_valid=0, stage=0. A NEXT pulse 3 cycles wide produces no state change.
- Full entry: sw=4'h5 + NEXT, sw=4'h3 + NEXT, sw=4'h1 + NEXT -> x=5, y=3, select=1, op_valid=1, commit_pulse high for exactly 1 cycle, stage=3. Each transition lands at edge 7 after raw rise.
- Atomicity: from READY with x=5/y=3/select=1, enter sw=4'hA then 4'h2 -> x/y/select stay 5/3/1 until the third press with sw=4'h7 commits x=A, y=2, select=7 on one edge.
- Opcode masking: enter X=1, Y=1, then sw=4'hE -> select=6.
- Collision: NEXT and CLEAR raised together in LOAD_OP -> stage=0, x=y=select=0, op_valid=0, no commit_pulse.
- Bounce and mid-reset: toggle NEXT raw every 2 cycles for 20 cycles, then hold high -> exactly one event. In a second run, assert rst mid-debounce -> no event after release.

Source files
------------

// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader: entry-stage encodings and
// the opcode map that the downstream ALU decodes.
package alu_operand_loader_pkg;

    // Entry FSM stages; values are driven straight onto the stage LEDs.
    typedef enum logic [1:0] {
        LOAD_X  = 2'd0,
        LOAD_Y  = 2'd1,
        LOAD_OP = 2'd2,
        READY   = 2'd3
    } stage_e;

    // Opcode map shared with the ALU.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    // Opcodes only use the low three switches; sw[3] is ignored.
    function automatic logic [2:0] opcode_of(input logic [3:0] sw);
        return sw[2:0];
    endfunction

endpackage

// File: rtl/alu_operand_loader_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on each accepted rising edge of the stable level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic rise_pulse
);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;

    // Synchroniser chain and debounce counter next-state.
    always_comb begin
        meta_d   = btn_raw;
        sync_d   = meta_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Pulse is registered, so it appears the cycle after the stable rise.
        rise_d = stable_d & ~stable_q;
    end

    // Conditioner state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign rise_pulse = rise_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Operand entry stage: X, Y and opcode are keyed in on one switch bank with
// NEXT presses, staged, then committed to the ALU on a single edge.
module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_next_raw,
    input  logic       btn_clr_raw,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [2:0] select,
    output logic       op_valid,
    output logic       commit_pulse,
    output logic [1:0] stage
);

    logic rst_meta_q, rst_meta_d;
    logic rst_sync_q, rst_sync_d;
    logic rst_n_int;

    // Reset bridge: asserts asynchronously, releases two edges after rst rises.
    always_comb begin
        rst_meta_d = 1'b1;
        rst_sync_d = rst_meta_q;
    end

    // Reset bridge registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= rst_meta_d;
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_int = rst_sync_q;

    logic next_ev;
    logic clr_ev;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_next (
        .clk        (clk),
        .rst_n      (rst_n_int),
        .btn_raw    (btn_next_raw),
        .rise_pulse (next_ev)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_clr (
        .clk        (clk),
        .rst_n      (rst_n_int),
        .btn_raw    (btn_clr_raw),
        .rise_pulse (clr_ev)
    );

    stage_e     stage_q, stage_d;
    logic [3:0] stg_x_q, stg_x_d;
    logic [3:0] stg_y_q, stg_y_d;
    logic [3:0] x_q, x_d;
    logic [3:0] y_q, y_d;
    logic [2:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic       pulse_q, pulse_d;

    // Entry FSM next-state; CLEAR takes priority over a coincident NEXT.
    // The opcode is not staged: it goes straight to select on the commit edge.
    always_comb begin
        stage_d = stage_q;
        stg_x_d = stg_x_q;
        stg_y_d = stg_y_q;
        x_d     = x_q;
        y_d     = y_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        pulse_d = 1'b0;
        if (clr_ev) begin
            stage_d = LOAD_X;
            stg_x_d = '0;
            stg_y_d = '0;
            x_d     = '0;
            y_d     = '0;
            sel_d   = '0;
            valid_d = 1'b0;
        end else if (next_ev) begin
            case (stage_q)
                LOAD_X: begin
                    stg_x_d = sw;
                    stage_d = LOAD_Y;
                end
                LOAD_Y: begin
                    stg_y_d = sw;
                    stage_d = LOAD_OP;
                end
                LOAD_OP: begin
                    x_d     = stg_x_q;
                    y_d     = stg_y_q;
                    sel_d   = opcode_of(sw);
                    valid_d = 1'b1;
                    pulse_d = 1'b1;
                    stage_d = READY;
                end
                READY: begin
                    stage_d = LOAD_X;
                end
                default: begin
                    stage_d = LOAD_X;
                end
            endcase
        end
    end

    // Entry FSM and committed-operation registers.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            stage_q <= LOAD_X;
            stg_x_q <= '0;
            stg_y_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            stg_x_q <= stg_x_d;
            stg_y_q <= stg_y_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign select       = sel_q;
    assign op_valid     = valid_q;
    assign commit_pulse = pulse_q;
    assign stage        = stage_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with DEBOUNCE_CYCLES=4.
module tb_alu_operand_loader;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       btn_next_raw;
    logic       btn_clr_raw;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] select;
    logic       op_valid;
    logic       commit_pulse;
    logic [1:0] stage;

    int checks = 0;
    int errors = 0;

    // Reference model: entry position as a count 0..3 plus committed values.
    int         m_stage;
    logic [3:0] m_x, m_y, m_sx, m_sy;
    logic [2:0] m_sel;
    logic       m_valid, m_pulse;

    alu_operand_loader #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .btn_next_raw (btn_next_raw),
        .btn_clr_raw  (btn_clr_raw),
        .x            (x),
        .y            (y),
        .select       (select),
        .op_valid     (op_valid),
        .commit_pulse (commit_pulse),
        .stage        (stage)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [14:0] obs();
        return {stage, x, y, select, op_valid, commit_pulse};
    endfunction

    function automatic logic [14:0] exp_vec();
        return {2'(m_stage), m_x, m_y, m_sel, m_valid, m_pulse};
    endfunction

    function automatic void model_reset();
        m_stage = 0;
        m_x = '0; m_y = '0; m_sx = '0; m_sy = '0;
        m_sel = '0; m_valid = 1'b0; m_pulse = 1'b0;
    endfunction

    function automatic void model_event(input logic nxt, input logic clr, input logic [3:0] s);
        m_pulse = 1'b0;
        if (clr) begin
            model_reset();
        end else if (nxt) begin
            if (m_stage == 0) m_sx = s;
            else if (m_stage == 1) m_sy = s;
            else if (m_stage == 2) begin
                m_x = m_sx;
                m_y = m_sy;
                m_sel = 3'(s % 8);
                m_valid = 1'b1;
                m_pulse = 1'b1;
            end
            m_stage = (m_stage + 1) % 4;
        end
    endfunction

    task automatic release_all();
        btn_next_raw = 1'b0;
        btn_clr_raw  = 1'b0;
        sw = 4'($urandom);
        tick(DB + 6);
    endtask

    // Clean press: snapshot after edge 6, 7 and 8 from the raw rise, then release.
    task automatic step(input logic nxt, input logic clr, input logic [3:0] s,
                        output logic [14:0] ob, output logic [14:0] oa, output logic [14:0] of);
        sw = s;
        btn_next_raw = nxt;
        btn_clr_raw  = clr;
        tick(6);
        ob = obs();
        tick(1);
        oa = obs();
        tick(1);
        of = obs();
        release_all();
    endtask

    task automatic test_reset();
        rst = 1'b0; sw = '0; btn_next_raw = 1'b0; btn_clr_raw = 1'b0;
        model_reset();
        tick(3);
        checks++;
        if (obs() !== 15'h0) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs(), 15'h0); end
        rst = 1'b1;
        tick(3);
        checks++;
        if (obs() !== exp_vec()) begin errors++; $display("FAIL reset_release: got %h expected %h", obs(), exp_vec()); end
        btn_next_raw = 1'b1;
        tick(3);
        btn_next_raw = 1'b0;
        tick(12);
        checks++;
        if (obs() !== exp_vec()) begin errors++; $display("FAIL short_glitch: got %h expected %h", obs(), exp_vec()); end
    endtask

    task automatic test_full_entry();
        logic [3:0]  vals [3];
        logic [14:0] pre, b, a, f;
        vals = '{4'h5, 4'h3, 4'h1};
        for (int i = 0; i < 3; i++) begin
            pre = exp_vec();
            step(1'b1, 1'b0, vals[i], b, a, f);
            model_event(1'b1, 1'b0, vals[i]);
            checks++;
            if (b !== pre) begin errors++; $display("FAIL entry%0d_edge6: got %h expected %h", i, b, pre); end
            checks++;
            if (a !== exp_vec()) begin errors++; $display("FAIL entry%0d_edge7: got %h expected %h", i, a, exp_vec()); end
            m_pulse = 1'b0;
            checks++;
            if (f !== exp_vec()) begin errors++; $display("FAIL entry%0d_edge8: got %h expected %h", i, f, exp_vec()); end
        end
        checks++;
        if ({stage, x, y, select, op_valid} !== {2'd3, 4'h5, 4'h3, 3'd1, 1'b1})
            begin errors++; $display("FAIL entry_result: got %h expected %h", {stage, x, y, select, op_valid}, {2'd3, 4'h5, 4'h3, 3'd1, 1'b1}); end
    endtask

    task automatic test_atomicity();
        logic [3:0]  vals [4];
        logic [14:0] pre, b, a, f;
        vals = '{4'h9, 4'hA, 4'h2, 4'h7};
        for (int i = 0; i < 4; i++) begin
            pre = exp_vec();
            step(1'b1, 1'b0, vals[i], b, a, f);
            model_event(1'b1, 1'b0, vals[i]);
            checks++;
            if (b !== pre) begin errors++; $display("FAIL atom%0d_edge6: got %h expected %h", i, b, pre); end
            checks++;
            if (a !== exp_vec()) begin errors++; $display("FAIL atom%0d_edge7: got %h expected %h", i, a, exp_vec()); end
            m_pulse = 1'b0;
            checks++;
            if (f !== exp_vec()) begin errors++; $display("FAIL atom%0d_edge8: got %h expected %h", i, f, exp_vec()); end
            if (i < 3) begin
                checks++;
                if ({x, y, select} !== {4'h5, 4'h3, 3'd1})
                    begin errors++; $display("FAIL atom_hold%0d: got %h expected %h", i, {x, y, select}, {4'h5, 4'h3, 3'd1}); end
            end
        end
        checks++;
        if ({x, y, select} !== {4'hA, 4'h2, 3'd7})
            begin errors++; $display("FAIL atom_commit: got %h expected %h", {x, y, select}, {4'hA, 4'h2, 3'd7}); end
    endtask

    task automatic test_opcode_mask();
        logic [3:0]  vals [4];
        logic [14:0] b, a, f;
        vals = '{4'h0, 4'h1, 4'h1, 4'hE};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, vals[i], b, a, f);
            model_event(1'b1, 1'b0, vals[i]);
            checks++;
            if (a !== exp_vec()) begin errors++; $display("FAIL mask%0d: got %h expected %h", i, a, exp_vec()); end
            m_pulse = 1'b0;
        end
        checks++;
        if (select !== 3'd6) begin errors++; $display("FAIL mask_select: got %0d expected %0d", select, 6); end
    endtask

    task automatic test_collision();
        logic [14:0] b, a, f;
        step(1'b0, 1'b1, 4'h0, b, a, f);
        model_event(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 4'(i + 6), b, a, f);
            model_event(1'b1, 1'b0, 4'(i + 6));
            m_pulse = 1'b0;
        end
        checks++;
        if (stage !== 2'd2) begin errors++; $display("FAIL collide_setup: got %0d expected %0d", stage, 2); end
        step(1'b1, 1'b1, 4'h5, b, a, f);
        model_event(1'b1, 1'b1, 4'h5);
        checks++;
        if (a !== 15'h0 || a !== exp_vec()) begin errors++; $display("FAIL collide_edge7: got %h expected %h", a, 15'h0); end
        checks++;
        if (f !== 15'h0) begin errors++; $display("FAIL collide_edge8: got %h expected %h", f, 15'h0); end
    endtask

    task automatic test_hold_and_bounce();
        logic [1:0] prev;
        int changes;
        // Held button: one event only.
        sw = 4'h4; btn_next_raw = 1'b1;
        prev = stage; changes = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (stage !== prev) changes++;
            prev = stage;
        end
        model_event(1'b1, 1'b0, 4'h4);
        m_pulse = 1'b0;
        release_all();
        checks++;
        if (changes !== 1) begin errors++; $display("FAIL hold_events: got %0d expected %0d", changes, 1); end
        checks++;
        if (obs() !== exp_vec()) begin errors++; $display("FAIL hold_state: got %h expected %h", obs(), exp_vec()); end
        // Bounce every 2 cycles, then hold: one event only.
        sw = 4'hB;
        prev = stage; changes = 0;
        for (int i = 0; i < 10; i++) begin
            btn_next_raw = (i % 2 == 0);
            for (int k = 0; k < 2; k++) begin
                tick(1);
                if (stage !== prev) changes++;
                prev = stage;
            end
        end
        btn_next_raw = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (stage !== prev) changes++;
            prev = stage;
        end
        model_event(1'b1, 1'b0, 4'hB);
        m_pulse = 1'b0;
        release_all();
        checks++;
        if (changes !== 1) begin errors++; $display("FAIL bounce_events: got %0d expected %0d", changes, 1); end
        checks++;
        if (obs() !== exp_vec()) begin errors++; $display("FAIL bounce_state: got %h expected %h", obs(), exp_vec()); end
    endtask

    task automatic test_mid_reset();
        logic [14:0] b, a, f;
        btn_next_raw = 1'b1; sw = 4'h6;
        tick(3);
        rst = 1'b0;
        tick(2);
        btn_next_raw = 1'b0;
        rst = 1'b1;
        model_reset();
        tick(15);
        checks++;
        if (obs() !== exp_vec()) begin errors++; $display("FAIL midreset_state: got %h expected %h", obs(), exp_vec()); end
        step(1'b1, 1'b0, 4'h3, b, a, f);
        model_event(1'b1, 1'b0, 4'h3);
        checks++;
        if (a !== exp_vec()) begin errors++; $display("FAIL midreset_fresh: got %h expected %h", a, exp_vec()); end
        m_pulse = 1'b0;
    endtask

    task automatic test_random();
        logic [14:0] pre, b, a, f;
        logic nxt, clr;
        logic [3:0] s;
        int r;
        for (int it = 0; it < 30; it++) begin
            r = int'($urandom_range(0, 9));
            s = 4'($urandom);
            if (r == 9) begin
                btn_next_raw = 1'b1; sw = s;
                tick(3);
                btn_next_raw = 1'b0;
                tick(12);
                checks++;
                if (obs() !== exp_vec()) begin errors++; $display("FAIL rand%0d_glitch: got %h expected %h", it, obs(), exp_vec()); end
            end else begin
                nxt = (r != 7);
                clr = (r >= 7);
                pre = exp_vec();
                step(nxt, clr, s, b, a, f);
                model_event(nxt, clr, s);
                checks++;
                if (b !== pre) begin errors++; $display("FAIL rand%0d_edge6: got %h expected %h", it, b, pre); end
                checks++;
                if (a !== exp_vec()) begin errors++; $display("FAIL rand%0d_edge7: got %h expected %h", it, a, exp_vec()); end
                m_pulse = 1'b0;
                checks++;
                if (f !== exp_vec()) begin errors++; $display("FAIL rand%0d_edge8: got %h expected %h", it, f, exp_vec()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_entry();
        test_atomicity();
        test_opcode_mask();
        test_collision();
        test_hold_and_bounce();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
